// File: rtl/matrix_result_serializer_pkg.sv
// Shared types and index helpers for the matrix result serializer (package matrix_pkg).
package matrix_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    // Index width with a floor of one bit so 1-row/1-column configs still get a port.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned elem_index(input int unsigned r,
                                               input int unsigned c,
                                               input int unsigned n_cols);
        return r * n_cols + c;
    endfunction

endpackage

// File: rtl/matrix_result_serializer_if.sv
// Capture-side and stream-side handshake bundle for matrix_result_serializer.
interface matrix_result_serializer_if #(
    parameter int unsigned m_rows     = 3,
    parameter int unsigned n_columns  = 3,
    parameter int unsigned elem_width = 8
);
    import matrix_pkg::*;

    localparam int unsigned mat_w = m_rows * n_columns * elem_width;
    localparam int unsigned row_w = idx_width(m_rows);
    localparam int unsigned col_w = idx_width(n_columns);

    logic                  in_valid;
    logic                  in_ready;
    logic [mat_w-1:0]      in_matrix;
    logic                  out_valid;
    logic                  out_ready;
    logic [elem_width-1:0] out_data;
    logic [row_w-1:0]      out_row;
    logic [col_w-1:0]      out_col;
    logic                  out_last;

    // Producer of matrices and consumer of elements.
    modport master (
        output in_valid, in_matrix, out_ready,
        input  in_ready, out_valid, out_data, out_row, out_col, out_last
    );

    // The serializer itself.
    modport slave (
        input  in_valid, in_matrix, out_ready,
        output in_ready, out_valid, out_data, out_row, out_col, out_last
    );

endinterface

// File: rtl/matrix_result_serializer_elem_select.sv
// Combinational pick of element (row,col) out of a packed row-major matrix.
module matrix_elem_select
    import matrix_pkg::*;
#(
    parameter int unsigned m_rows     = 3,
    parameter int unsigned n_columns  = 3,
    parameter int unsigned elem_width = 8
) (
    input  logic [m_rows*n_columns*elem_width-1:0] i_matrix,
    input  logic [idx_width(m_rows)-1:0]           i_row,
    input  logic [idx_width(n_columns)-1:0]        i_col,
    output logic [elem_width-1:0]                  o_elem_c
);

    localparam int unsigned row_w = idx_width(m_rows);
    localparam int unsigned col_w = idx_width(n_columns);

    // Decoded mux over legal indices only; out-of-range indices yield zero.
    always_comb begin
        o_elem_c = '0;
        for (int unsigned r = 0; r < m_rows; r++) begin
            for (int unsigned c = 0; c < n_columns; c++) begin
                if (i_row == row_w'(r) && i_col == col_w'(c)) begin
                    o_elem_c = i_matrix[elem_index(r, c, n_columns)*elem_width +: elem_width];
                end
            end
        end
    end

endmodule

// File: rtl/matrix_result_serializer.sv
// Captures one packed result matrix and streams it row-major, one element per beat.
// Optional MATRIX_SER_BACK_TO_BACK_EN lets a new capture overlap the last beat.
module matrix_result_serializer
    import matrix_pkg::*;
#(
    parameter int unsigned m_rows     = 3,
    parameter int unsigned n_columns  = 3,
    parameter int unsigned elem_width = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    matrix_result_serializer_if.slave   bus
);

    localparam int unsigned mat_w = m_rows * n_columns * elem_width;
    localparam int unsigned row_w = idx_width(m_rows);
    localparam int unsigned col_w = idx_width(n_columns);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [row_w-1:0]   r_row;
    logic [row_w-1:0]   w_row_nxt;
    logic [col_w-1:0]   r_col;
    logic [col_w-1:0]   w_col_nxt;
    logic [mat_w-1:0]   r_cap;
    logic [mat_w-1:0]   w_cap_nxt;
    logic               w_in_ready;
    logic               w_last;
    logic [elem_width-1:0] w_elem;

    assign w_last = (r_state == STREAM)
                 && (r_row == row_w'(m_rows - 1))
                 && (r_col == col_w'(n_columns - 1));

    // State, indices and capture register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_row   <= '0;
            r_col   <= '0;
            r_cap   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_row   <= w_row_nxt;
            r_col   <= w_col_nxt;
            r_cap   <= w_cap_nxt;
        end
    end

    // Next-state, index walk and capture handshake.
    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        w_col_nxt   = r_col;
        w_cap_nxt   = r_cap;
        w_in_ready  = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_cap_nxt   = bus.in_matrix;
                    w_row_nxt   = '0;
                    w_col_nxt   = '0;
                    w_state_nxt = STREAM;
                end
            end
            STREAM: begin
                if (bus.out_ready) begin
                    if (w_last) begin
                        w_state_nxt = IDLE;
                        w_row_nxt   = '0;
                        w_col_nxt   = '0;
`ifdef MATRIX_SER_BACK_TO_BACK_EN
                        // Accept the next matrix on the final beat so streaming never gaps.
                        w_in_ready = 1'b1;
                        if (bus.in_valid) begin
                            w_cap_nxt   = bus.in_matrix;
                            w_state_nxt = STREAM;
                        end
`endif
                    end else if (r_col == col_w'(n_columns - 1)) begin
                        w_col_nxt = '0;
                        w_row_nxt = r_row + row_w'(1);
                    end else begin
                        w_col_nxt = r_col + col_w'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    matrix_elem_select #(
        .m_rows     (m_rows),
        .n_columns  (n_columns),
        .elem_width (elem_width)
    ) u_elem_select (
        .i_matrix (r_cap),
        .i_row    (r_row),
        .i_col    (r_col),
        .o_elem_c (w_elem)
    );

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state == STREAM);
    assign bus.out_data  = w_elem;
    assign bus.out_row   = r_row;
    assign bus.out_col   = r_col;
    assign bus.out_last  = w_last;

endmodule

// File: tb/tb_matrix_result_serializer.sv
// Directed bench for matrix_result_serializer: 3x3 instance plus a 1x1 instance.
module tb_matrix_result_serializer;
    import matrix_pkg::*;

    localparam int unsigned MW = 72;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    bit   btb;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    matrix_result_serializer_if #(.m_rows(3), .n_columns(3), .elem_width(8)) bus ();
    matrix_result_serializer_if #(.m_rows(1), .n_columns(1), .elem_width(8)) bus1 ();

    matrix_result_serializer #(.m_rows(3), .n_columns(3), .elem_width(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    matrix_result_serializer #(.m_rows(1), .n_columns(1), .elem_width(8)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    typedef struct {
        logic          iv;
        logic [MW-1:0] mat;
        logic          ordy;
        logic          e_irdy;
        logic          e_ov;
        logic [7:0]    e_d;
        logic [1:0]    e_r;
        logic [1:0]    e_c;
        logic          e_last;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [MW-1:0] mk(input int base);
        logic [MW-1:0] m;
        m = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                m[(r*3+c)*8 +: 8] = 8'(base + 10*r + c);
        return m;
    endfunction

    task automatic add(input logic iv, input logic [MW-1:0] mat, input logic ordy,
                       input logic irdy, input logic ov, input int d,
                       input int r, input int c, input logic last);
        vec_t v;
        v.iv = iv; v.mat = mat; v.ordy = ordy;
        v.e_irdy = irdy; v.e_ov = ov; v.e_d = 8'(d);
        v.e_r = 2'(r); v.e_c = 2'(c); v.e_last = last;
        vecs.push_back(v);
    endtask

    task automatic drain();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            #1;
            if (!bus.out_valid) break;
        end
        check("drain out_valid", 32'(bus.out_valid), 32'd0);
    endtask

    logic [MW-1:0] mat_a;
    logic [MW-1:0] mat_b;
    int exp_seq[18] = '{0, 1, 2, 10, 11, 12, 20, 21, 22,
                        100, 101, 102, 110, 111, 112, 120, 121, 122};

    initial begin
        int acc;
        int irdy_busy;
        int beat_cyc[$];
        int beat_d[$];
`ifdef MATRIX_SER_BACK_TO_BACK_EN
        btb = 1'b1;
`else
        btb = 1'b0;
`endif
        errors = 0;
        checks = 0;
        mat_a  = mk(0);
        mat_b  = mk(100);
        rst_n  = 1'b0;
        bus.in_valid   = 1'b0; bus.in_matrix  = '0; bus.out_ready  = 1'b0;
        bus1.in_valid  = 1'b0; bus1.in_matrix = '0; bus1.out_ready = 1'b0;

        // Reset state of both instances.
        #12;
        check("rst in_ready",  32'(bus.in_ready),  32'd1);
        check("rst out_valid", 32'(bus.out_valid), 32'd0);
        check("rst out_last",  32'(bus.out_last),  32'd0);
        check("rst out_data",  32'(bus.out_data),  32'd0);
        check("rst out_row",   32'(bus.out_row),   32'd0);
        check("rst out_col",   32'(bus.out_col),   32'd0);
        check("rst1 in_ready", 32'(bus1.in_ready), 32'd1);
        check("rst1 out_valid",32'(bus1.out_valid),32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single matrix, then backpressure with a second matrix held on in_valid while busy.
        add(1, mat_a, 1, 1,   0, 0,   0, 0, 0);
        add(0, mat_a, 1, 0,   1, 0,   0, 0, 0);
        add(0, mat_a, 1, 0,   1, 1,   0, 1, 0);
        add(0, mat_a, 1, 0,   1, 2,   0, 2, 0);
        add(0, mat_a, 1, 0,   1, 10,  1, 0, 0);
        add(0, mat_a, 1, 0,   1, 11,  1, 1, 0);
        add(0, mat_a, 1, 0,   1, 12,  1, 2, 0);
        add(0, mat_a, 1, 0,   1, 20,  2, 0, 0);
        add(0, mat_a, 1, 0,   1, 21,  2, 1, 0);
        add(0, mat_a, 1, btb, 1, 22,  2, 2, 1);
        add(1, mat_b, 0, 1,   0, 0,   0, 0, 0);
        add(1, mat_a, 1, 0,   1, 100, 0, 0, 0);
        add(1, mat_a, 0, 0,   1, 101, 0, 1, 0);
        add(1, mat_a, 0, 0,   1, 101, 0, 1, 0);
        add(1, mat_a, 1, 0,   1, 101, 0, 1, 0);
        add(1, mat_a, 1, 0,   1, 102, 0, 2, 0);
        add(1, mat_a, 1, 0,   1, 110, 1, 0, 0);
        add(1, mat_a, 1, 0,   1, 111, 1, 1, 0);
        add(1, mat_a, 1, 0,   1, 112, 1, 2, 0);
        add(1, mat_a, 1, 0,   1, 120, 2, 0, 0);
        add(1, mat_a, 1, 0,   1, 121, 2, 1, 0);
        add(1, mat_a, 0, 0,   1, 122, 2, 2, 1);
        add(0, mat_a, 1, btb, 1, 122, 2, 2, 1);
        add(1, mat_a, 1, 1,   0, 0,   0, 0, 0);
        add(0, mat_a, 1, 0,   1, 0,   0, 0, 0);
        add(0, mat_a, 1, 0,   1, 1,   0, 1, 0);
        add(0, mat_a, 1, 0,   1, 2,   0, 2, 0);
        add(0, mat_a, 1, 0,   1, 10,  1, 0, 0);
        add(0, mat_a, 1, 0,   1, 11,  1, 1, 0);
        add(0, mat_a, 1, 0,   1, 12,  1, 2, 0);
        add(0, mat_a, 1, 0,   1, 20,  2, 0, 0);
        add(0, mat_a, 1, 0,   1, 21,  2, 1, 0);
        add(0, mat_a, 1, btb, 1, 22,  2, 2, 1);
        add(0, mat_a, 0, 1,   0, 0,   0, 0, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            bus.in_valid  = vecs[i].iv;
            bus.in_matrix = vecs[i].mat;
            bus.out_ready = vecs[i].ordy;
            #1;
            check($sformatf("v%0d in_ready", i),  32'(bus.in_ready),  32'(vecs[i].e_irdy));
            check($sformatf("v%0d out_valid", i), 32'(bus.out_valid), 32'(vecs[i].e_ov));
            check($sformatf("v%0d out_last", i),  32'(bus.out_last),  32'(vecs[i].e_last));
            if (vecs[i].e_ov) begin
                check($sformatf("v%0d out_data", i), 32'(bus.out_data), 32'(vecs[i].e_d));
                check($sformatf("v%0d out_row", i),  32'(bus.out_row),  32'(vecs[i].e_r));
                check($sformatf("v%0d out_col", i),  32'(bus.out_col),  32'(vecs[i].e_c));
            end
        end

        // Asynchronous reset after four accepted beats.
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_matrix = mat_a; bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        check("pre-rst out_data", 32'(bus.out_data), 32'd11);
        rst_n = 1'b0;
        #1;
        check("arst out_valid", 32'(bus.out_valid), 32'd0);
        check("arst in_ready",  32'(bus.in_ready),  32'd1);
        check("arst out_row",   32'(bus.out_row),   32'd0);
        check("arst out_col",   32'(bus.out_col),   32'd0);
        check("arst out_data",  32'(bus.out_data),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("post-rst idle", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_matrix = mat_b;
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        check("post-rst out_data", 32'(bus.out_data),  32'd100);
        check("post-rst out_row",  32'(bus.out_row),   32'd0);
        check("post-rst out_col",  32'(bus.out_col),   32'd0);
        drain();

        // Two matrices presented continuously.
        acc = 0;
        irdy_busy = 0;
        for (int cyc = 0; cyc < 40 && beat_d.size() < 18; cyc++) begin
            @(negedge clk);
            bus.in_valid  = (acc < 2);
            bus.in_matrix = (acc == 0) ? mat_a : mat_b;
            bus.out_ready = 1'b1;
            #1;
            if (bus.out_valid && bus.in_ready && bus.in_valid) irdy_busy++;
            if (bus.out_valid) begin
                beat_d.push_back(int'(bus.out_data));
                beat_cyc.push_back(cyc);
            end
            if (bus.in_valid && bus.in_ready) acc++;
        end
        bus.in_valid = 1'b0;
        check("b2b beat count", 32'(beat_d.size()), 32'd18);
        if (beat_d.size() == 18) begin
            for (int i = 0; i < 18; i++)
                check($sformatf("b2b beat%0d data", i), 32'(beat_d[i]), 32'(exp_seq[i]));
            check("b2b gap", 32'(beat_cyc[9] - beat_cyc[8]), btb ? 32'd1 : 32'd2);
            check("b2b second span", 32'(beat_cyc[17] - beat_cyc[9]), 32'd8);
            check("b2b first span", 32'(beat_cyc[8] - beat_cyc[0]), 32'd8);
        end
        check("b2b in_ready while busy", 32'(irdy_busy), btb ? 32'd1 : 32'd0);
        drain();

        // 1x1 configuration.
        @(negedge clk);
        bus1.in_valid = 1'b1; bus1.in_matrix = 8'hA5; bus1.out_ready = 1'b1;
        #1;
        check("1x1 in_ready idle", 32'(bus1.in_ready), 32'd1);
        @(negedge clk);
        bus1.in_valid = 1'b0;
        #1;
        check("1x1 out_valid", 32'(bus1.out_valid), 32'd1);
        check("1x1 out_data",  32'(bus1.out_data),  32'hA5);
        check("1x1 out_last",  32'(bus1.out_last),  32'd1);
        check("1x1 out_row",   32'(bus1.out_row),   32'd0);
        check("1x1 out_col",   32'(bus1.out_col),   32'd0);
        check("1x1 in_ready last", 32'(bus1.in_ready), 32'(btb));
        @(negedge clk);
        #1;
        check("1x1 done out_valid", 32'(bus1.out_valid), 32'd0);
        check("1x1 done in_ready",  32'(bus1.in_ready),  32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/matrix_result_serializer.md
Name: matrix_result_serializer

Overview:
- Consumer end of the matrix multiplier's flattened result bus.
- Captures one packed m_rows x n_columns result matrix with a valid/ready handshake.
- Streams the captured matrix out one element per beat, row-major, with its row/column index and a last flag.
- Feeds result checkers and narrow downstream sinks that cannot take the full-width product bus.

Parameters:
- m_rows, 3, number of matrix rows.
- n_columns, 3, number of matrix columns.
- elem_width, 8, bits per result element.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; asynchronous, active-low.
- in_valid  input  1  in_matrix holds a valid result matrix.
- in_ready  output  1  block can capture a matrix this cycle.
- in_matrix  input  m_rows*n_columns*elem_width  packed matrix; element (r,c) at bits [(r*n_columns+c)*elem_width +: elem_width].
- out_valid  output  1  out_data/out_row/out_col/out_last are valid.
- out_ready  input  1  downstream accepts the current element.
- out_data  output  elem_width  current element.
- out_row  output  clog2(m_rows) (min 1)  row index of out_data.
- out_col  output  clog2(n_columns) (min 1)  column index of out_data.
- out_last  output  1  high on element (m_rows-1, n_columns-1).

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, in_ready=1, out_valid=0, out_last=0, out_row=0, out_col=0, out_data=0, capture register cleared. Reset mid-stream abandons the matrix; no further beats of it are emitted.
- FSM has two states, IDLE and STREAM.
- IDLE: in_ready=1, out_valid=0. On in_valid&&in_ready, register in_matrix, set row=col=0, go to STREAM.
- STREAM: in_ready=0, out_valid=1.
  - out_data = captured element (row,col), driven from registered indices and the capture register (no combinational path from in_matrix).
- Latency: first element is valid the cycle after the capture handshake.
- Beat: out_valid&&out_ready.
  - col<n_columns-1: col+1.
  - col==n_columns-1: col=0, row+1.
  - On the last element: return to IDLE.
- Stall: while out_ready=0, all out_* hold stable.
- in_valid in STREAM is ignored (not captured). Upstream holds the matrix until in_ready.
- Throughput without the optional feature is one matrix per m_rows*n_columns+1 cycles (one idle capture cycle).
- out_last = out_valid && row==m_rows-1 && col==n_columns-1.
- Degenerate 1x1 matrix: the single beat has out_last=1.
- Elements are passed unmodified. No arithmetic or width change.

Optional Feature:
- Macro MATRIX_SER_BACK_TO_BACK_EN.
- Defined:
  - in_ready = (state==IDLE) || (state==STREAM && out_last && out_ready). This is a combinational path from out_ready to in_ready.
  - A capture coinciding with the last beat loads the new matrix, resets indices, and stays in STREAM.
  - Sustained throughput is one element per cycle with no gap between matrices.
- Undefined: in_ready is registered state only, and there is always one idle cycle between matrices.

Decomposition:
- Shared package matrix_pkg:
  - state enum (IDLE, STREAM);
  - index-width helper function (clog2 with minimum 1);
  - element index function r*n_columns+c.
- Sub-module matrix_elem_select: combinational mux selecting element (row,col) from the packed capture register. It is reused by the future vector deserializer.

Test Plan (m_rows=3, n_columns=3, elem_width=8 unless noted):
- Single matrix: capture elements 10*r+c, out_ready=1 -> 9 beats on consecutive cycles starting 1 cycle after capture: data 0,1,2,10,11,12,20,21,22; out_row/out_col match; out_last only on 22; then in_ready=1.
- Backpressure: out_ready toggled 1,0,0,1,... -> outputs stable through stalls; exactly 9 beats; order unchanged.
- Ignore while busy: in_valid held with a different matrix during streaming -> in_ready=0; the first matrix's 9 elements are emitted unchanged; the second is captured only after return to IDLE.
- Async reset mid-stream: assert rst_n=0 after beat 4 between clock edges -> out_valid=0 and in_ready=1 immediately, indices 0; a new matrix afterwards starts at element (0,0).
- Back-to-back (MATRIX_SER_BACK_TO_BACK_EN): two matrices presented continuously -> 18 consecutive beats with no gap; in_ready pulses only on the last-beat cycle. Without the macro -> one idle cycle between matrices.
- 1x1 config (m_rows=n_columns=1): capture 0xA5 -> one beat, data 0xA5, out_last=1, row=col=0.
